gate_truth_checker: RTL and testbench



---
 rtl/gate_chk_pkg.sv | 29 ++
 rtl/gate_ref_model.sv | 23 ++
 rtl/gate_truth_checker.sv | 138 +++++++++++++
 tb/tb_gate_truth_checker.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate truth-table self-test block.
// Optional behaviour in gate_truth_checker is selected by GATE_CHK_STOP_ON_FAIL_EN.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    GATE_NOT  = 2'd0,
    GATE_AND  = 2'd1,
    GATE_OR   = 2'd2,
    GATE_NAND = 2'd3
  } gate_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } chk_state_e;

  localparam logic [2:0] NUM_VEC_NOT = 3'd2;
  localparam logic [2:0] NUM_VEC_2IN = 3'd4;

  // Index of the final vector applied for the selected gate.
  function automatic logic [1:0] lastVecIdx(input gate_sel_e sel);
    logic [2:0] n;
    n = (sel == GATE_NOT) ? NUM_VEC_NOT : NUM_VEC_2IN;
    return 2'(n - 3'd1);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational truth-table reference for the basic gate library.
// Reusable wherever an expected gate output is needed from (gate_sel, a, b).
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  gate_sel_e i_gateSel,
  input  logic      i_a,
  input  logic      i_b,
  output logic      o_y
);

  always_comb begin
    o_y = 1'b0;
    unique case (i_gateSel)
      GATE_NOT:  o_y = ~i_a;
      GATE_AND:  o_y = i_a & i_b;
      GATE_OR:   o_y = i_a | i_b;
      GATE_NAND: o_y = ~(i_a & i_b);
      default:   o_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Drives every input vector into one gate, waits SETTLE_CYCLES, samples and grades it.
// Define GATE_CHK_STOP_ON_FAIL_EN to end a run at the first mismatching vector.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] gate_sel,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  chk_state_e r_state;
  gate_sel_e  r_gateSel;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_dutA;
  logic       r_dutB;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_failVec;
  logic [2:0] r_errCount;

  logic       w_expected;
  logic       w_mismatch;
  logic       w_lastVec;
  logic       w_endRun;
  logic [1:0] w_idxNext;
  logic [2:0] w_errNext;

  gate_ref_model u_ref (
    .i_gateSel (r_gateSel),
    .i_a       (r_dutA),
    .i_b       (r_dutB),
    .o_y       (w_expected)
  );

  assign w_mismatch = (dut_y != w_expected);
  assign w_lastVec  = (r_idx == lastVecIdx(r_gateSel));
  assign w_idxNext  = r_idx + 2'd1;
  assign w_errNext  = r_errCount + {2'b00, w_mismatch};

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  assign w_endRun = w_lastVec | w_mismatch;
`else
  assign w_endRun = w_lastVec;
`endif

  // Single-process FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gateSel  <= GATE_NOT;
      r_idx      <= 2'd0;
      r_cnt      <= 4'd0;
      r_dutA     <= 1'b0;
      r_dutB     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_failVec  <= 4'd0;
      r_errCount <= 3'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_gateSel  <= gate_sel_e'(gate_sel);
            r_idx      <= 2'd0;
            r_cnt      <= 4'd0;
            r_failVec  <= 4'd0;
            r_errCount <= 3'd0;
            r_pass     <= 1'b0;
            r_dutA     <= 1'b0;
            r_dutB     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (w_mismatch) begin
            r_failVec[r_idx] <= 1'b1;
          end
          r_errCount <= w_errNext;
          if (w_endRun) begin
            r_pass  <= (w_errNext == 3'd0);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_dutA  <= 1'b0;
            r_dutB  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            // NOT only ever reaches index 1, so b stays 0 without special casing.
            r_idx   <= w_idxNext;
            r_cnt   <= 4'd0;
            r_dutA  <= w_idxNext[0];
            r_dutB  <= w_idxNext[1];
            r_state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dut_a     = r_dutA;
  assign dut_b     = r_dutB;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_vec  = r_failVec;
  assign err_count = r_errCount;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: a behavioural gate sits on dut_a/dut_b -> dut_y and
// each run is graded against truth tables; honours GATE_CHK_STOP_ON_FAIL_EN.
`timescale 1ns/1ps
module tb_gate_truth_checker;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] gate_sel;
  logic       dut_a;
  logic       dut_b;
  logic       dut_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [2:0] err_count;
  logic [3:0] connTable;

  int compared   = 0;
  int mismatched = 0;

  gate_truth_checker #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .gate_sel  (gate_sel),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_y     (dut_y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_vec  (fail_vec),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // The "connected gate": output looked up from a truth table indexed by {b,a}.
  always_comb begin
    dut_y = connTable[{dut_b, dut_a}];
  end

  function automatic logic [3:0] truthTable(input int g);
    case (g)
      0:       return 4'b0101;
      1:       return 4'b1000;
      2:       return 4'b1110;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [3:0] conn, input bit disturb,
                               input int abortAt);
    logic [3:0] refT;
    logic [3:0] expFail;
    int nVec, nApplied, expErr, lat, doneCycle, busyErr, stimErr, extraDone, expVec;
    refT     = truthTable(sel);
    nVec     = (sel == 0) ? 2 : 4;
    nApplied = nVec;
    expFail  = 4'd0;
    expErr   = 0;
    for (int i = 0; i < nVec; i++) begin
      if (i < nApplied && conn[i] != refT[i]) begin
        expFail[i] = 1'b1;
        expErr++;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        nApplied = i + 1;
`endif
      end
    end
    lat = nApplied * (S + 1) + 1;

    @(negedge clk);
    connTable = conn;
    gate_sel  = 2'(sel);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    doneCycle = 0;
    busyErr   = 0;
    stimErr   = 0;
    for (int c = 1; c <= lat + 4 && doneCycle == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (abortAt > 0 && c == abortAt) begin
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstOutputs",
                    int'({dut_a, dut_b, busy, done, pass, fail_vec, err_count}), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstIdle", int'({busy, done}), 0);
        return;
      end
      expVec = (c < lat) ? ((c - 1) / (S + 1)) : 0;
      if ({dut_b, dut_a} != expVec[1:0]) stimErr++;
      if (busy != (c < lat)) busyErr++;
      if (done) doneCycle = c;
      if (disturb) begin
        start    = done ? 1'b1 : 1'($urandom_range(0, 1));
        gate_sel = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    start     = 1'b0;
    gate_sel  = 2'(sel);
    extraDone = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (done || busy) extraDone++;
    end
    checkOutput("doneCycle", doneCycle, lat);
    checkOutput("busyProfile", busyErr, 0);
    checkOutput("stimSequence", stimErr, 0);
    checkOutput("extraActivity", extraDone, 0);
    checkOutput("pass", int'(pass), (expErr == 0) ? 1 : 0);
    checkOutput("failVec", int'(fail_vec), int'(expFail));
    checkOutput("errCount", int'(err_count), expErr);
  endtask

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] conn;
    int sel;
    rst       = 1'b1;
    start     = 1'b0;
    gate_sel  = 2'd0;
    connTable = 4'b1000;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs",
                int'({dut_a, dut_b, busy, done, pass, fail_vec, err_count}), 0);
    rst = 1'b0;

    applyStimulus(1, truthTable(1), 1'b0, 0);
    applyStimulus(0, truthTable(0), 1'b0, 0);
    applyStimulus(1, truthTable(2), 1'b0, 0);
    applyStimulus(1, truthTable(2), 1'b0, 8);
    applyStimulus(1, truthTable(1), 1'b0, 0);
    applyStimulus(2, truthTable(2), 1'b1, 0);
    applyStimulus(3, truthTable(1), 1'b0, 0);
    applyStimulus(0, truthTable(3), 1'b0, 0);

    for (int r = 0; r < 20; r++) begin
      sel = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) conn = truthTable(sel);
      else conn = 4'($urandom_range(0, 15));
      applyStimulus(sel, conn, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
